// File: rtl/key_sample_conditioner.sv
// key_sample_conditioner
// Conditions a raw, bouncing active-low push-button and a raw slide switch
// into a one-cycle sample strobe plus the sampled data bit, for use as the
// state-update enable and data input of a downstream sequence detector.
// Both raw inputs are asynchronous to clock. Each one passes through a
// two-flop synchronizer before any other logic uses it.
module key_sample_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  input  logic       sw_in,
  output logic       sample_valid,
  output logic       sample_bit,
  output logic       key_level,
  output logic [7:0] press_count
);

  // Debouncer states: bit 1 set means the key is debounced as pressed.
  localparam logic [1:0] IDLE_UP   = 2'd0;
  localparam logic [1:0] WAIT_DOWN = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] WAIT_UP   = 2'd3;

  // Terminal count: a level must persist this many counted cycles after the
  // first sighting before the debouncer accepts it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchronizer stages. The key chain resets to the released level.
  logic             key_meta_r;
  logic             key_sync_r;
  logic             sw_meta_r;
  logic             sw_sync_r;

  // Debouncer state and counter.
  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;

  // Next-state values computed combinationally.
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             strobe_s;
  logic             level_nxt_s;

  // Registered output copies.
  logic             sample_valid_r;
  logic             sample_bit_r;
  logic             key_level_r;
  logic [7:0]       press_count_r;

  // Two-flop synchronizers for the asynchronous key and switch inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_meta_r <= 1'b1;
      key_sync_r <= 1'b1;
      sw_meta_r  <= 1'b0;
      sw_sync_r  <= 1'b0;
    end else begin
      key_meta_r <= key_n;
      key_sync_r <= key_meta_r;
      sw_meta_r  <= sw_in;
      sw_sync_r  <= sw_meta_r;
    end
  end

  // Debounce FSM next state. The counter clears on every state change, and a
  // bounce back to the previous level returns to the previous stable state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    strobe_s    = 1'b0;
    case (state_r)
      IDLE_UP: begin
        if (key_sync_r == 1'b0) begin
          state_nxt_s = WAIT_DOWN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = IDLE_UP;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      WAIT_DOWN: begin
        if (key_sync_r == 1'b1) begin
          state_nxt_s = IDLE_UP;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = HELD;
          cnt_nxt_s   = CNT_ZERO;
          strobe_s    = 1'b1;
        end else begin
          state_nxt_s = WAIT_DOWN;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      HELD: begin
        if (key_sync_r == 1'b1) begin
          state_nxt_s = WAIT_UP;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = HELD;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      WAIT_UP: begin
        if (key_sync_r == 1'b0) begin
          state_nxt_s = HELD;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = IDLE_UP;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = WAIT_UP;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE_UP;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Debounced key level for the next state, so key_level updates together with the state.
  always_comb begin
    if ((state_nxt_s == HELD) || (state_nxt_s == WAIT_UP)) begin
      level_nxt_s = 1'b1;
    end else begin
      level_nxt_s = 1'b0;
    end
  end

  // Debounce state and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE_UP;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Output registers: the strobe, the captured switch bit and the press counter
  // all update on the edge that accepts a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_valid_r <= 1'b0;
      sample_bit_r   <= 1'b0;
      key_level_r    <= 1'b0;
      press_count_r  <= 8'd0;
    end else begin
      sample_valid_r <= strobe_s;
      key_level_r    <= level_nxt_s;
      if (strobe_s) begin
        sample_bit_r  <= sw_sync_r;
        press_count_r <= press_count_r + 8'd1;
      end else begin
        sample_bit_r  <= sample_bit_r;
        press_count_r <= press_count_r;
      end
    end
  end

  assign sample_valid = sample_valid_r;
  assign sample_bit   = sample_bit_r;
  assign key_level    = key_level_r;
  assign press_count  = press_count_r;

endmodule
